multi_hand_scorer: RTL and testbench

Parametrised, sequential successor to the combinational baccarat hand scorer. It accumulates a stream of dealt cards into NUM_HANDS independent modulo-MOD running totals and tracks card counts and naturals per hand. On request it settles the round and reports the winning hand. It sits between the deal datapath (card source) and the display/result logic of the card-game top level.

---
 rtl/multi_hand_scorer_if.sv | 36 +++
 rtl/multi_hand_scorer.sv | 170 +++++++++++++++++
 tb/tb_multi_hand_scorer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_hand_scorer_if.sv
// rtl/multi_hand_scorer_if.sv - card stream, settlement request and result bundle for multi_hand_scorer
interface multi_hand_scorer_if #(
    parameter int CARD_W    = 4,
    parameter int MOD       = 10,
    parameter int MAX_CARDS = 3,
    parameter int NUM_HANDS = 2
) ();
    localparam int TOT_W  = $clog2(MOD);
    localparam int CNT_W  = $clog2(MAX_CARDS + 1);
    localparam int HAND_W = $clog2(NUM_HANDS);

    logic                         clear;
    logic                         card_valid;
    logic [HAND_W-1:0]            card_hand;
    logic [CARD_W-1:0]            card_value;
    logic                         card_ready;
    logic                         card_err;
    logic                         score_req;
    logic [NUM_HANDS*TOT_W-1:0]   total;
    logic [NUM_HANDS*CNT_W-1:0]   count;
    logic [NUM_HANDS-1:0]         natural;
    logic [NUM_HANDS-1:0]         full;
    logic [HAND_W-1:0]            winner;
    logic                         tie;
    logic                         result_valid;

    modport master (
        output clear, card_valid, card_hand, card_value, score_req,
        input  card_ready, card_err, total, count, natural, full, winner, tie, result_valid
    );

    modport slave (
        input  clear, card_valid, card_hand, card_value, score_req,
        output card_ready, card_err, total, count, natural, full, winner, tie, result_valid
    );
endinterface

// File: rtl/multi_hand_scorer.sv
// rtl/multi_hand_scorer.sv - accumulates dealt cards into per-hand modulo totals and settles the winner
module multi_hand_scorer #(
    parameter int CARD_W      = 4,
    parameter int MOD         = 10,
    parameter int MAX_CARDS   = 3,
    parameter int NUM_HANDS   = 2,
    parameter int NATURAL_MIN = 8,
    parameter int FACE_MAX    = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_hand_scorer_if.slave    bus
);
    localparam int TOT_W  = $clog2(MOD);
    localparam int CNT_W  = $clog2(MAX_CARDS + 1);
    localparam int HAND_W = $clog2(NUM_HANDS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DEAL   = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [CARD_W-1:0] MOD_V   = CARD_W'(MOD);
    localparam logic [CARD_W-1:0] FACE_V  = CARD_W'(FACE_MAX);
    localparam logic [TOT_W:0]    MOD_S   = (TOT_W + 1)'(MOD);
    localparam logic [TOT_W:0]    NAT_V   = (TOT_W + 1)'(NATURAL_MIN);
    localparam logic [CNT_W-1:0]  MAX_V   = CNT_W'(MAX_CARDS);
    localparam logic [CNT_W-1:0]  TWO_V   = CNT_W'(2);
    localparam logic [HAND_W:0]   HANDS_V = (HAND_W + 1)'(NUM_HANDS);

    logic [1:0]        state;
    logic              ready_r;
    logic [TOT_W-1:0]  tot_r [NUM_HANDS];
    logic [CNT_W-1:0]  cnt_r [NUM_HANDS];
    logic [HAND_W-1:0] winner_r;
    logic              tie_r;
    logic              rv_r;
    logic              err_r;

    logic              card_ok;
    logic [TOT_W-1:0]  sel_tot;
    logic [CNT_W-1:0]  sel_cnt;
    logic [TOT_W-1:0]  pip;
    logic [TOT_W:0]    sum;
    logic [TOT_W-1:0]  sum_wrap;

    // Both addends are below MOD, so one conditional subtract completes the modulo.
    always_comb begin
        sel_tot = '0;
        sel_cnt = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            if (bus.card_hand == HAND_W'(h)) begin
                sel_tot = tot_r[h];
                sel_cnt = cnt_r[h];
            end
        end
        pip      = (bus.card_value < MOD_V) ? bus.card_value[TOT_W-1:0] : '0;
        sum      = {1'b0, sel_tot} + {1'b0, pip};
        sum_wrap = (sum >= MOD_S) ? TOT_W'(sum - MOD_S) : sum[TOT_W-1:0];
        card_ok  = (bus.card_value != '0) && (bus.card_value <= FACE_V)
                && ({1'b0, bus.card_hand} < HANDS_V) && (sel_cnt != MAX_V);
    end

    logic [TOT_W-1:0]  best_tot;
    logic [HAND_W-1:0] best_idx;
    logic              best_multi;

    // Strict greater-than keeps the lowest index on equal totals.
    always_comb begin
        best_tot   = tot_r[0];
        best_idx   = '0;
        best_multi = 1'b0;
        for (int h = 1; h < NUM_HANDS; h++) begin
            if (tot_r[h] > best_tot) begin
                best_tot   = tot_r[h];
                best_idx   = HAND_W'(h);
                best_multi = 1'b0;
            end else if (tot_r[h] == best_tot) begin
                best_multi = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ready_r  <= 1'b0;
            winner_r <= '0;
            tie_r    <= 1'b0;
            rv_r     <= 1'b0;
            err_r    <= 1'b0;
            for (int h = 0; h < NUM_HANDS; h++) begin
                tot_r[h] <= '0;
                cnt_r[h] <= '0;
            end
        end else begin
            rv_r  <= 1'b0;
            err_r <= 1'b0;
            if (bus.clear) begin
                state    <= IDLE;
                ready_r  <= 1'b1;
                winner_r <= '0;
                tie_r    <= 1'b0;
                for (int h = 0; h < NUM_HANDS; h++) begin
                    tot_r[h] <= '0;
                    cnt_r[h] <= '0;
                end
            end else begin
                case (state)
                    IDLE, DEAL: begin
                        ready_r <= !bus.score_req;
                        if (bus.score_req) begin
                            state <= SETTLE;
                        end else if (bus.card_valid && ready_r) begin
                            if (card_ok) begin
                                state <= DEAL;
                                for (int h = 0; h < NUM_HANDS; h++) begin
                                    if (bus.card_hand == HAND_W'(h)) begin
                                        tot_r[h] <= sum_wrap;
                                        cnt_r[h] <= cnt_r[h] + CNT_W'(1);
                                    end
                                end
                            end else begin
                                err_r <= 1'b1;
                            end
                        end
                    end
                    SETTLE: begin
                        ready_r  <= 1'b0;
                        winner_r <= best_idx;
                        tie_r    <= best_multi;
                        rv_r     <= 1'b1;
                        state    <= DONE;
                    end
                    default: begin
                        ready_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic [NUM_HANDS*TOT_W-1:0] total_v;
    logic [NUM_HANDS*CNT_W-1:0] count_v;
    logic [NUM_HANDS-1:0]       natural_v;
    logic [NUM_HANDS-1:0]       full_v;

    always_comb begin
        total_v   = '0;
        count_v   = '0;
        natural_v = '0;
        full_v    = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            total_v[h*TOT_W +: TOT_W] = tot_r[h];
            count_v[h*CNT_W +: CNT_W] = cnt_r[h];
            natural_v[h] = (cnt_r[h] == TWO_V) && ({1'b0, tot_r[h]} >= NAT_V);
            full_v[h]    = (cnt_r[h] == MAX_V);
        end
    end

    assign bus.card_ready   = ready_r;
    assign bus.card_err     = err_r;
    assign bus.total        = total_v;
    assign bus.count        = count_v;
    assign bus.natural      = natural_v;
    assign bus.full         = full_v;
    assign bus.winner       = winner_r;
    assign bus.tie          = tie_r;
    assign bus.result_valid = rv_r;
endmodule

// File: tb/tb_multi_hand_scorer.sv
// tb/tb_multi_hand_scorer.sv - bench for multi_hand_scorer with default and 4-hand/mod-8 instances
module tb_multi_hand_scorer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_hand_scorer_if bus0 ();
    multi_hand_scorer_if #(.MOD(8), .NUM_HANDS(4)) bus1 ();

    multi_hand_scorer u0 (.clk(clk), .reset(reset), .bus(bus0));
    multi_hand_scorer #(.MOD(8), .NUM_HANDS(4)) u1 (.clk(clk), .reset(reset), .bus(bus1));

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        bit clr; bit v; int hand; int val; bit req;
        int tot0; int tot1; int cnt0; int nat1; int err; int rv; int rdy; int win; int tie;
    } vec_t;

    vec_t vecs[25];

    // Reference state for the default instance: 0 idle, 1 deal, 2 settle, 3 done.
    int m_tot[2];
    int m_cnt[2];
    int m_state, m_ready, m_err, m_rv, m_win, m_tie;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit clr, bit v, int hand, int val, bit req,
                                int tot0, int tot1, int cnt0, int nat1,
                                int err, int rv, int rdy, int win, int tie);
        vec_t r;
        r.clr = clr; r.v = v; r.hand = hand; r.val = val; r.req = req;
        r.tot0 = tot0; r.tot1 = tot1; r.cnt0 = cnt0; r.nat1 = nat1;
        r.err = err; r.rv = rv; r.rdy = rdy; r.win = win; r.tie = tie;
        return r;
    endfunction

    task automatic model_step(input bit rst, input bit clr, input bit v,
                              input int hand, input int val, input bit req);
        int mx, n, first;
        m_err = 0;
        m_rv  = 0;
        if (rst || clr) begin
            m_tot = '{0, 0};
            m_cnt = '{0, 0};
            m_state = 0; m_win = 0; m_tie = 0;
            m_ready = rst ? 0 : 1;
        end else if (m_state <= 1) begin
            if (req) begin
                m_state = 2;
                m_ready = 0;
            end else begin
                if (v && m_ready == 1) begin
                    if (val >= 1 && val <= 13 && hand < 2 && m_cnt[hand] < 3) begin
                        m_tot[hand] = (m_tot[hand] + ((val < 10) ? val : 0)) % 10;
                        m_cnt[hand] = m_cnt[hand] + 1;
                        m_state = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                m_ready = 1;
            end
        end else if (m_state == 2) begin
            mx = 0;
            for (int h = 0; h < 2; h++) if (m_tot[h] > mx) mx = m_tot[h];
            n = 0; first = -1;
            for (int h = 0; h < 2; h++) begin
                if (m_tot[h] == mx) begin
                    n++;
                    if (first < 0) first = h;
                end
            end
            m_win = first; m_tie = (n > 1) ? 1 : 0; m_rv = 1; m_state = 3;
        end
    endtask

    task automatic compare_model();
        for (int h = 0; h < 2; h++) begin
            chk($sformatf("model total%0d", h), int'(bus0.total[h*4 +: 4]), m_tot[h]);
            chk($sformatf("model count%0d", h), int'(bus0.count[h*2 +: 2]), m_cnt[h]);
            chk($sformatf("model natural%0d", h), int'(bus0.natural[h]),
                (m_cnt[h] == 2 && m_tot[h] >= 8) ? 1 : 0);
            chk($sformatf("model full%0d", h), int'(bus0.full[h]), (m_cnt[h] == 3) ? 1 : 0);
        end
        chk("model card_ready", int'(bus0.card_ready), m_ready);
        chk("model card_err", int'(bus0.card_err), m_err);
        chk("model result_valid", int'(bus0.result_valid), m_rv);
        chk("model winner", int'(bus0.winner), m_win);
        chk("model tie", int'(bus0.tie), m_tie);
    endtask

    task automatic step(input bit clr, input bit v, input int hand, input int val, input bit req);
        bus0.clear      = clr;
        bus0.card_valid = v;
        bus0.card_hand  = 1'(hand);
        bus0.card_value = 4'(val);
        bus0.score_req  = req;
        @(posedge clk);
        model_step(reset, clr, v, hand, val, req);
        #1;
        compare_model();
    endtask

    task automatic step1(input bit v, input int hand, input int val);
        bus1.card_valid = v;
        bus1.card_hand  = 2'(hand);
        bus1.card_value = 4'(val);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        bus1.card_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus1.clear = 1'b0; bus1.card_valid = 1'b0; bus1.card_hand = '0;
        bus1.card_value = '0; bus1.score_req = 1'b0;
        m_tot = '{0, 0}; m_cnt = '{0, 0};
        m_state = 0; m_ready = 0; m_err = 0; m_rv = 0; m_win = 0; m_tie = 0;

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset total", int'(bus0.total), 0);
        chk("reset ready", int'(bus0.card_ready), 0);
        reset = 1'b0;
        step(0, 0, 0, 0, 0);
        chk("ready after reset", int'(bus0.card_ready), 1);

        vecs[0]  = mk(0,1,0, 7,0, 7,0,1,0, 0,0,1,0,0);
        vecs[1]  = mk(0,1,0, 5,0, 2,0,2,0, 0,0,1,0,0);
        vecs[2]  = mk(0,1,0, 9,0, 1,0,3,0, 0,0,1,0,0);
        vecs[3]  = mk(0,1,0, 3,0, 1,0,3,0, 1,0,1,0,0);
        vecs[4]  = mk(0,1,1, 4,0, 1,4,3,0, 0,0,1,0,0);
        vecs[5]  = mk(0,1,1, 4,0, 1,8,3,1, 0,0,1,0,0);
        vecs[6]  = mk(0,1,0,14,0, 1,8,3,1, 1,0,1,0,0);
        vecs[7]  = mk(0,1,0, 0,0, 1,8,3,1, 1,0,1,0,0);
        vecs[8]  = mk(0,0,0, 0,1, 1,8,3,1, 0,0,0,0,0);
        vecs[9]  = mk(0,0,0, 0,0, 1,8,3,1, 0,1,0,1,0);
        vecs[10] = mk(0,1,1, 2,0, 1,8,3,1, 0,0,0,1,0);
        vecs[11] = mk(1,1,0, 5,0, 0,0,0,0, 0,0,1,0,0);
        vecs[12] = mk(0,1,1, 4,0, 0,4,0,0, 0,0,1,0,0);
        vecs[13] = mk(0,1,1, 4,0, 0,8,0,1, 0,0,1,0,0);
        vecs[14] = mk(0,1,1, 2,0, 0,0,0,0, 0,0,1,0,0);
        vecs[15] = mk(0,1,0,12,0, 0,0,1,0, 0,0,1,0,0);
        vecs[16] = mk(0,1,0, 6,0, 6,0,2,0, 0,0,1,0,0);
        vecs[17] = mk(1,0,0, 0,0, 0,0,0,0, 0,0,1,0,0);
        vecs[18] = mk(0,1,0, 6,0, 6,0,1,0, 0,0,1,0,0);
        vecs[19] = mk(0,1,1, 6,0, 6,6,1,0, 0,0,1,0,0);
        vecs[20] = mk(0,1,0, 1,1, 6,6,1,0, 0,0,0,0,0);
        vecs[21] = mk(0,0,0, 0,0, 6,6,1,0, 0,1,0,0,1);
        vecs[22] = mk(1,0,0, 0,0, 0,0,0,0, 0,0,1,0,0);
        vecs[23] = mk(0,0,0, 0,1, 0,0,0,0, 0,0,0,0,0);
        vecs[24] = mk(0,0,0, 0,0, 0,0,0,0, 0,1,0,0,1);

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].clr, vecs[i].v, vecs[i].hand, vecs[i].val, vecs[i].req);
            chk($sformatf("vec%0d total0", i), int'(bus0.total[3:0]), vecs[i].tot0);
            chk($sformatf("vec%0d total1", i), int'(bus0.total[7:4]), vecs[i].tot1);
            chk($sformatf("vec%0d count0", i), int'(bus0.count[1:0]), vecs[i].cnt0);
            chk($sformatf("vec%0d natural1", i), int'(bus0.natural[1]), vecs[i].nat1);
            chk($sformatf("vec%0d card_err", i), int'(bus0.card_err), vecs[i].err);
            chk($sformatf("vec%0d result_valid", i), int'(bus0.result_valid), vecs[i].rv);
            chk($sformatf("vec%0d card_ready", i), int'(bus0.card_ready), vecs[i].rdy);
            chk($sformatf("vec%0d winner", i), int'(bus0.winner), vecs[i].win);
            chk($sformatf("vec%0d tie", i), int'(bus0.tie), vecs[i].tie);
        end

        // Reset in the middle of a deal discards the hands.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 3, 0);
        step(0, 1, 0, 4, 0);
        chk("mid count0", int'(bus0.count[1:0]), 2);
        reset = 1'b1;
        step(0, 1, 1, 5, 0);
        chk("mid reset total", int'(bus0.total), 0);
        chk("mid reset count", int'(bus0.count), 0);
        chk("mid reset flags", int'({bus0.natural, bus0.full, bus0.card_ready, bus0.card_err,
                                    bus0.result_valid, bus0.tie, bus0.winner}), 0);
        reset = 1'b0;
        step(0, 0, 0, 0, 0);

        // Four hands, modulus 8.
        step1(1, 3, 7);
        chk("u1 total3 7", int'(bus1.total[9 +: 3]), 7);
        step1(1, 3, 1);
        chk("u1 total3 wrap", int'(bus1.total[9 +: 3]), 0);
        chk("u1 count3", int'(bus1.count[6 +: 2]), 2);
        step1(1, 2, 9);
        chk("u1 total2 pip0", int'(bus1.total[6 +: 3]), 0);
        chk("u1 count2", int'(bus1.count[4 +: 2]), 1);
        step1(1, 0, 5);
        step1(1, 0, 6);
        chk("u1 total0 wrap", int'(bus1.total[0 +: 3]), 3);
        chk("u1 card_err", int'(bus1.card_err), 0);
        reset = 1'b1;
        step1(1, 1, 2);
        chk("u1 reset total", int'(bus1.total), 0);
        chk("u1 reset count", int'(bus1.count), 0);
        reset = 1'b0;
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 $urandom_range(0, 15) == 0);
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
